// File: rtl/fq_pkg.sv
// Shared types and helpers for the instruction fetch queue: default widths,
// mask popcount and lane-slice offset arithmetic for packed lane buses.
package fq_pkg;

    localparam int IW_DEF = 16;
    localparam int AW_DEF = 9;

    // Number of set bits in a fetch mask of up to four lanes.
    function automatic logic [2:0] popcount(input logic [3:0] mask);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + {2'b00, mask[i]};
        end
        return sum;
    endfunction

    // Low bit of lane 'lane' in a packed bus whose lanes are 'width' bits wide.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fq_compact.sv
// Maps a fetch lane mask to the destination slot offset of each surviving lane
// (number of valid lanes below it) and the total number of survivors.
module fq_compact
    import fq_pkg::*;
#(
    parameter int LANES = 2,
    parameter int OW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]    mask,
    output logic [LANES*OW-1:0] offs,
    output logic [OW-1:0]       total
);

    logic [OW-1:0] run_s;

    // Prefix sum over the mask gives each lane its compacted position.
    always_comb begin
        run_s = {OW{1'b0}};
        offs  = {(LANES*OW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            offs[i*OW +: OW] = run_s;
            run_s = run_s + OW'(mask[i]);
        end
        total = OW'(popcount(4'(mask)));
    end

endmodule

// File: rtl/fetch_queue.sv
// In-order multi-lane fetch buffer: compacts masked fetch groups into a circular
// queue and presents the oldest LANES entries to the issue lanes.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int IW    = IW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [AW-1:0]                fetch_pc,
    input  logic [LANES*IW-1:0]          fetch_ir,
    input  logic [LANES-1:0]             fetch_mask,
    output logic                         fetch_ready,
    output logic [LANES-1:0]             issue_valid,
    output logic [LANES*IW-1:0]          issue_ir,
    output logic [LANES*AW-1:0]          issue_pc,
    input  logic [$clog2(LANES+1)-1:0]   issue_take,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(LANES + 1);

    logic [IW-1:0]       ir_mem_r [DEPTH];
    logic [AW-1:0]       pc_mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [LANES*TW-1:0] offs_s;
    logic [TW-1:0]       pop_s;
    logic [TW-1:0]       take_s;
    logic [TW-1:0]       add_s;
    logic                acc_s;
    logic                ready_s;

    fq_compact #(.LANES(LANES), .OW(TW)) u_compact (
        .mask  (fetch_mask),
        .offs  (offs_s),
        .total (pop_s)
    );

    // Readiness looks at current occupancy only, never at this cycle's issue_take.
    assign ready_s     = ({1'b0, count_r} + (CW+1)'(LANES)) <= (CW+1)'(DEPTH);
    assign fetch_ready = ready_s;
    assign acc_s       = fetch_valid && ready_s && !flush && !rst;
    assign count       = count_r;

    // Clamp the consumer's take to the current occupancy and size the enqueue.
    always_comb begin
        if (CW'(issue_take) > count_r) begin
            take_s = TW'(count_r);
        end else begin
            take_s = issue_take;
        end
        if (acc_s) begin
            add_s = pop_s;
        end else begin
            add_s = {TW{1'b0}};
        end
    end

    // Storage write: survivors land on consecutive slots from the write pointer.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (fetch_mask[i]) begin
                    ir_mem_r[wr_ptr_r + PW'(offs_s[i*TW +: TW])] <= fetch_ir[lane_lo(i, IW) +: IW];
                    pc_mem_r[wr_ptr_r + PW'(offs_s[i*TW +: TW])] <= fetch_pc + AW'(i);
                end
            end
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(add_s);
            rd_ptr_r <= rd_ptr_r + PW'(take_s);
            count_r  <= count_r + CW'(add_s) - CW'(take_s);
        end
    end

    // Issue view of the oldest entries; invalid lanes are forced to zero.
    always_comb begin
        issue_valid = {LANES{1'b0}};
        issue_ir    = {(LANES*IW){1'b0}};
        issue_pc    = {(LANES*AW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (count_r > CW'(i)) begin
                issue_valid[i]                = 1'b1;
                issue_ir[lane_lo(i, IW) +: IW] = ir_mem_r[rd_ptr_r + PW'(i)];
                issue_pc[lane_lo(i, AW) +: AW] = pc_mem_r[rd_ptr_r + PW'(i)];
            end else begin
                issue_valid[i]                = 1'b0;
                issue_ir[lane_lo(i, IW) +: IW] = {IW{1'b0}};
                issue_pc[lane_lo(i, AW) +: AW] = {AW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (LANES=2, DEPTH=8): hand-computed checks plus a
// queue reference model compared against every issue output after each edge.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [8:0]  fetch_pc;
    logic [31:0] fetch_ir;
    logic [1:0]  fetch_mask;
    logic        fetch_ready;
    logic [1:0]  issue_valid;
    logic [31:0] issue_ir;
    logic [17:0] issue_pc;
    logic [1:0]  issue_take;
    logic        flush;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    logic [15:0] q_ir[$];
    logic [8:0]  q_pc[$];
    logic        last_acc;
    logic        track;
    int          last_pc;
    int          issued_n;

    fetch_queue #(.LANES(2), .DEPTH(8), .IW(16), .AW(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_ir    (fetch_ir),
        .fetch_mask  (fetch_mask),
        .fetch_ready (fetch_ready),
        .issue_valid (issue_valid),
        .issue_ir    (issue_ir),
        .issue_pc    (issue_pc),
        .issue_take  (issue_take),
        .flush       (flush),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the reference queue from the current inputs, step, compare.
    task automatic tick();
        int t;
        chk("take_legal", 32'(issue_take <= count), 32'd1);
        t = int'(issue_take);
        last_acc = 1'b0;
        if (rst || flush) begin
            q_ir.delete();
            q_pc.delete();
        end else begin
            last_acc = fetch_valid && ((8 - q_pc.size()) >= 2);
            for (int j = 0; j < t; j++) begin
                if (track) begin
                    chk("pc_incr", 32'(int'(issue_pc[j*9 +: 9]) > last_pc), 32'd1);
                    last_pc = int'(issue_pc[j*9 +: 9]);
                    issued_n++;
                end
                if (q_pc.size() > 0) begin
                    void'(q_ir.pop_front());
                    void'(q_pc.pop_front());
                end
            end
            if (last_acc) begin
                for (int l = 0; l < 2; l++) begin
                    if (fetch_mask[l]) begin
                        q_ir.push_back(fetch_ir[l*16 +: 16]);
                        q_pc.push_back(9'(fetch_pc + 9'(l)));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(q_pc.size()));
        chk("ready", 32'(fetch_ready), 32'((8 - q_pc.size()) >= 2));
        chk("valid", 32'(issue_valid), 32'({q_pc.size() > 1, q_pc.size() > 0}));
        for (int l = 0; l < 2; l++) begin
            chk("lane_ir", 32'(issue_ir[l*16 +: 16]), (l < q_ir.size()) ? 32'(q_ir[l]) : 32'd0);
            chk("lane_pc", 32'(issue_pc[l*9 +: 9]),   (l < q_pc.size()) ? 32'(q_pc[l]) : 32'd0);
        end
    endtask

    task automatic group(input logic [8:0] pc, input logic [1:0] mask, input logic [1:0] take);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_ir    = {7'h2B, pc, 7'h1A, pc};
        fetch_mask  = mask;
        issue_take  = take;
        tick();
        fetch_valid = 1'b0;
        issue_take  = 2'd0;
    endtask

    initial begin
        int cyc;
        int groups;
        logic [8:0] pc_next;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = 9'd0;
        fetch_ir = 32'd0; fetch_mask = 2'b00; issue_take = 2'd0;
        track = 1'b0; last_pc = -1; issued_n = 0; last_acc = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_ir", issue_ir, 32'd0);

        // Full group, both lanes valid.
        fetch_valid = 1'b1; fetch_pc = 9'h010; fetch_ir = {16'hB222, 16'hA111};
        fetch_mask = 2'b11; issue_take = 2'd0;
        tick();
        fetch_valid = 1'b0;
        chk("g1_valid", 32'(issue_valid), 32'h3);
        chk("g1_ir0", 32'(issue_ir[15:0]), 32'hA111);
        chk("g1_pc0", 32'(issue_pc[8:0]), 32'h010);
        chk("g1_ir1", 32'(issue_ir[31:16]), 32'hB222);
        chk("g1_pc1", 32'(issue_pc[17:9]), 32'h011);
        issue_take = 2'd2;
        tick();
        issue_take = 2'd0;

        // Lane 0 masked off after a branch target.
        fetch_valid = 1'b1; fetch_pc = 9'h020; fetch_ir = {16'hC333, 16'hDEAD};
        fetch_mask = 2'b10;
        tick();
        fetch_valid = 1'b0;
        chk("m10_ir0", 32'(issue_ir[15:0]), 32'hC333);
        chk("m10_pc0", 32'(issue_pc[8:0]), 32'h021);
        chk("m10_count", 32'(count), 32'd1);
        chk("m10_valid", 32'(issue_valid), 32'h1);
        issue_take = 2'd1;
        tick();
        issue_take = 2'd0;

        // Fill toward capacity; the held group at 0x1FF also exercises PC wrap.
        group(9'h100, 2'b11, 2'd0);
        group(9'h102, 2'b11, 2'd0);
        group(9'h104, 2'b01, 2'd0);
        group(9'h106, 2'b11, 2'd0);
        chk("c7_count", 32'(count), 32'd7);
        chk("c7_ready", 32'(fetch_ready), 32'd0);
        group(9'h1FF, 2'b11, 2'd0);
        chk("held_count", 32'(count), 32'd7);
        group(9'h1FF, 2'b11, 2'd1);
        chk("c6_ready", 32'(fetch_ready), 32'd1);
        group(9'h1FF, 2'b11, 2'd0);
        chk("c8_count", 32'(count), 32'd8);
        chk("c8_ready", 32'(fetch_ready), 32'd0);
        issue_take = 2'd2;
        tick();
        chk("free_ready", 32'(fetch_ready), 32'd1);
        cyc = 0;
        while (q_pc.size() > 0 && cyc < 20) begin
            issue_take = (q_pc.size() > 1) ? 2'd2 : 2'd1;
            tick();
            cyc++;
        end
        issue_take = 2'd0;

        // Wrap-around: 20 groups, alternating take 1/2, producer holds on stall.
        track = 1'b1; pc_next = 9'h040; groups = 0; cyc = 0;
        while (groups < 20 && cyc < 200) begin
            fetch_valid = 1'b1; fetch_pc = pc_next; fetch_mask = 2'b11;
            fetch_ir = {7'h11, pc_next + 9'd1, 7'h22, pc_next};
            issue_take = 2'((q_pc.size() < ((cyc % 2) + 1)) ? q_pc.size() : ((cyc % 2) + 1));
            tick();
            if (last_acc) begin
                groups++;
                pc_next = pc_next + 9'd2;
            end
            cyc++;
        end
        fetch_valid = 1'b0;
        cyc = 0;
        while (q_pc.size() > 0 && cyc < 40) begin
            issue_take = (q_pc.size() > 1) ? 2'd2 : 2'd1;
            tick();
            cyc++;
        end
        issue_take = 2'd0;
        track = 1'b0;
        chk("wrap_groups", 32'(groups), 32'd20);
        chk("wrap_issued", 32'(issued_n), 32'd40);
        chk("wrap_empty", 32'(count), 32'd0);

        // Flush with count 5 while a group and a take are presented.
        group(9'h080, 2'b11, 2'd0);
        group(9'h082, 2'b11, 2'd0);
        group(9'h084, 2'b01, 2'd0);
        chk("pre_flush", 32'(count), 32'd5);
        flush = 1'b1;
        group(9'h0F0, 2'b11, 2'd2);
        flush = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", 32'(issue_valid), 32'd0);
        chk("fl_ready", 32'(fetch_ready), 32'd1);
        tick();
        chk("fl_gone", 32'(issue_valid), 32'd0);
        group(9'h130, 2'b11, 2'd0);
        chk("post_fl_pc", 32'(issue_pc[8:0]), 32'h130);

        // Reset mid-operation with a group presented.
        group(9'h140, 2'b11, 2'd0);
        rst = 1'b1;
        group(9'h150, 2'b11, 2'd1);
        rst = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(issue_valid), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
